// File: rtl/mult_sequencer.sv
// mult_sequencer: Moore controller for the shift-add multiplier datapath.
// It sequences LOAD, then ANCHO rounds of CHECK/(ADD)/SHIFT/TEST, then DONE.
// A watchdog parks the FSM in ERROR when the datapath Zero flag disagrees
// with the internal iteration count. ciclos reports the busy-cycle latency
// of the most recent operation.
module mult_sequencer #(
    parameter int ANCHO = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Q_Cero,
    input  logic             Zero,
    output logic             Load_regs,
    output logic             Add_regs,
    output logic             Shift_regs,
    output logic             Decr_P,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] ciclos
);

    localparam int                ITER_W    = $clog2(ANCHO + 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ANCHO);
    localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);
    localparam logic [ITER_W-1:0] ITER_ZERO = {ITER_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_TEST  = 3'd5,
        S_DONE  = 3'd6,
        S_ERROR = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [ITER_W-1:0] iter_q,  iter_d;
    logic [CNT_W-1:0]  ciclos_q, ciclos_d;
    logic              counting_s;

    // State, iteration counter and latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            iter_q   <= ITER_ZERO;
            ciclos_q <= CNT_ZERO;
        end else begin
            state_q  <= state_d;
            iter_q   <= iter_d;
            ciclos_q <= ciclos_d;
        end
    end

    // Next-state logic; TEST is the watchdog that cross-checks Zero with iter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
                else       state_d = S_IDLE;
            end
            S_LOAD:  state_d = S_CHECK;
            S_CHECK: begin
                if (Q_Cero) state_d = S_ADD;
                else        state_d = S_SHIFT;
            end
            S_ADD:   state_d = S_SHIFT;
            S_SHIFT: state_d = S_TEST;
            S_TEST: begin
                if (Zero && (iter_q == ITER_LAST))       state_d = S_DONE;
                else if (!Zero && (iter_q < ITER_LAST))  state_d = S_CHECK;
                else                                     state_d = S_ERROR;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: begin
                if (start) state_d = S_LOAD;
                else       state_d = S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counters: both restart on entry to LOAD; iter counts shifts, ciclos
    // counts every cycle of the CHECK..TEST loop and saturates.
    always_comb begin
        iter_d   = iter_q;
        ciclos_d = ciclos_q;
        if (state_d == S_LOAD) begin
            iter_d   = ITER_ZERO;
            ciclos_d = CNT_ONE;
        end else begin
            if (state_q == S_SHIFT) iter_d = iter_q + ITER_ONE;
            else                    iter_d = iter_q;
            if (counting_s && (ciclos_q != CNT_MAX)) ciclos_d = ciclos_q + CNT_ONE;
            else                                     ciclos_d = ciclos_q;
        end
    end

    // Moore output decode of the registered state only.
    always_comb begin
        Load_regs  = 1'b0;
        Add_regs   = 1'b0;
        Shift_regs = 1'b0;
        Decr_P     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        counting_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_LOAD: begin
                Load_regs = 1'b1;
                busy      = 1'b1;
            end
            S_CHECK: begin
                busy       = 1'b1;
                counting_s = 1'b1;
            end
            S_ADD: begin
                Add_regs   = 1'b1;
                busy       = 1'b1;
                counting_s = 1'b1;
            end
            S_SHIFT: begin
                Shift_regs = 1'b1;
                Decr_P     = 1'b1;
                busy       = 1'b1;
                counting_s = 1'b1;
            end
            S_TEST: begin
                busy       = 1'b1;
                counting_s = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign ciclos = ciclos_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: drives the sequencer with a behavioural shift-add
// datapath and checks products, latency, strobe order and the watchdog
// against arithmetic expectations (a*b, popcount-based cycle counts).
module tb_mult_sequencer;

    localparam int ANCHO = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             zero_s;
    logic             Load_regs, Add_regs, Shift_regs, Decr_P;
    logic             busy, done, error;
    logic [CNT_W-1:0] ciclos;

    // Behavioural datapath (no reset, like the real one)
    logic [7:0] dp_a, dp_q, dp_m, dp_mplier, dp_mcand;
    logic       dp_c;
    logic [3:0] dp_p;
    int         zero_mode = 0; // 0 normal, 1 premature Zero after 3 shifts, 2 Zero stuck low

    int checks = 0;
    int errors = 0;

    // observations collected by run_op
    int          obs_busy, obs_adds, obs_done_cyc, obs_viol;
    bit          obs_done, obs_err, obs_first_load, obs_first_err;
    logic [15:0] obs_prod;
    logic [7:0]  obs_ciclos;
    string       obs_trace;

    always #5 clk = ~clk;

    mult_sequencer #(.ANCHO(ANCHO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .Q_Cero(dp_q[0]), .Zero(zero_s),
        .Load_regs(Load_regs), .Add_regs(Add_regs), .Shift_regs(Shift_regs),
        .Decr_P(Decr_P), .busy(busy), .done(done), .error(error), .ciclos(ciclos)
    );

    assign zero_s = (zero_mode == 2) ? 1'b0 :
                    ((zero_mode == 1) && (dp_p == 4'd5)) ? 1'b1 : (dp_p == 4'd0);

    // Datapath acts on the edge that ends each strobe cycle
    always @(posedge clk) begin
        if (Load_regs) begin
            dp_a <= 8'd0; dp_c <= 1'b0; dp_q <= dp_mplier; dp_m <= dp_mcand;
        end else if (Add_regs) begin
            {dp_c, dp_a} <= {1'b0, dp_a} + {1'b0, dp_m};
        end else if (Shift_regs) begin
            {dp_c, dp_a, dp_q} <= {1'b0, dp_c, dp_a, dp_q[7:1]};
        end
        if (Load_regs)   dp_p <= 4'd8;
        else if (Decr_P) dp_p <= dp_p - 4'd1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int exp_cycles(input logic [7:0] m);
        return 1 + 3 * ANCHO + $countones(m);
    endfunction

    function automatic string model_trace(input logic [7:0] m);
        string s;
        s = "L";
        for (int i = 0; i < ANCHO; i++) begin
            s = {s, "-"};
            if (m[i]) s = {s, "A"};
            s = {s, "S-"};
        end
        return s;
    endfunction

    // Starts one operation and records what happens until done/error/timeout
    task automatic run_op(input logic [7:0] mplier, input logic [7:0] mcand, input bit hold);
        dp_mplier = mplier; dp_mcand = mcand;
        obs_busy = 0; obs_adds = 0; obs_done_cyc = -1; obs_viol = 0;
        obs_done = 0; obs_err = 0; obs_first_load = 0; obs_first_err = 1;
        obs_prod = 16'hxxxx; obs_ciclos = 8'hxx; obs_trace = "";
        @(negedge clk); start = 1'b1;
        @(negedge clk); if (!hold) start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (c == 0) begin obs_first_load = Load_regs; obs_first_err = error; end
            if (busy) begin
                obs_busy++;
                if (Load_regs)       obs_trace = {obs_trace, "L"};
                else if (Add_regs)   obs_trace = {obs_trace, "A"};
                else if (Shift_regs) obs_trace = {obs_trace, "S"};
                else                 obs_trace = {obs_trace, "-"};
                if (Add_regs) obs_adds++;
                if ((int'(Load_regs) + int'(Add_regs) + int'(Shift_regs)) > 1 || Decr_P !== Shift_regs)
                    obs_viol++;
            end
            if (done) begin
                obs_done = 1; obs_done_cyc = c; obs_prod = {dp_a, dp_q}; obs_ciclos = ciclos;
                break;
            end
            if (error) begin obs_err = 1; obs_ciclos = ciclos; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; zero_mode = 0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({Load_regs, Add_regs, Shift_regs, Decr_P, busy, done, error} !== 7'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 0000000",
                {Load_regs, Add_regs, Shift_regs, Decr_P, busy, done, error});
        end
        checks++;
        if (ciclos !== 8'd0) begin errors++; $display("FAIL reset_ciclos: got %0d expected 0", ciclos); end
        rst = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy got %b expected 0", busy); end
    endtask

    task automatic check_full_op(input string name, input logic [7:0] m, input logic [7:0] mc);
        int exp_c;
        exp_c = exp_cycles(m);
        checks++;
        if (obs_done !== 1'b1) begin errors++; $display("FAIL %s done_seen: got %b expected 1", name, obs_done); end
        checks++;
        if (obs_prod !== 16'(m * mc)) begin errors++; $display("FAIL %s product: got %h expected %h", name, obs_prod, 16'(m * mc)); end
        checks++;
        if (int'(obs_ciclos) !== exp_c) begin errors++; $display("FAIL %s ciclos: got %0d expected %0d", name, obs_ciclos, exp_c); end
        checks++;
        if (obs_busy !== exp_c || obs_done_cyc !== exp_c) begin
            errors++; $display("FAIL %s latency: busy %0d done_at %0d expected %0d", name, obs_busy, obs_done_cyc, exp_c);
        end
        checks++;
        if (obs_adds !== $countones(m)) begin errors++; $display("FAIL %s adds: got %0d expected %0d", name, obs_adds, $countones(m)); end
        checks++;
        if (obs_trace != model_trace(m)) begin errors++; $display("FAIL %s trace: got %s expected %s", name, obs_trace, model_trace(m)); end
        checks++;
        if (obs_viol !== 0) begin errors++; $display("FAIL %s strobe_rules: got %0d violations expected 0", name, obs_viol); end
    endtask

    task automatic test_normal();
        run_op(8'h17, 8'hD7, 1'b0);
        check_full_op("normal", 8'h17, 8'hD7);
        checks++;
        if (obs_ciclos !== 8'd29) begin errors++; $display("FAIL normal_ciclos29: got %0d expected 29", obs_ciclos); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b expected 0", done); end
        @(negedge clk); @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ciclos !== 8'd29) begin
            errors++; $display("FAIL idle_frozen: busy %b ciclos %0d expected 0 / 29", busy, ciclos);
        end
    endtask

    task automatic test_extremes();
        logic [7:0] mc;
        mc = 8'($urandom);
        run_op(8'h00, mc, 1'b0);
        check_full_op("mult00", 8'h00, mc);
        run_op(8'hFF, 8'hFF, 1'b0);
        check_full_op("multFF", 8'hFF, 8'hFF);
        checks++;
        if (obs_prod !== 16'hFE01 || obs_ciclos !== 8'd33) begin
            errors++; $display("FAIL ff_const: got %h/%0d expected FE01/33", obs_prod, obs_ciclos);
        end
    endtask

    task automatic test_random();
        logic [7:0] m, mc;
        for (int i = 0; i < 16; i++) begin
            m = 8'($urandom); mc = 8'($urandom);
            run_op(m, mc, 1'b0);
            check_full_op("random", m, mc);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] m, mc;
        bit found;
        m = 8'($urandom) | 8'h01; mc = 8'($urandom);
        dp_mplier = m; dp_mcand = mc;
        found = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (Add_regs) begin found = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL reset_mid_add_seen: got 0 expected 1"); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({Load_regs, Add_regs, Shift_regs, Decr_P, busy, done, error} !== 7'b0 || ciclos !== 8'd0) begin
            errors++; $display("FAIL reset_mid_async: outputs %b ciclos %0d expected 0/0",
                {Load_regs, Add_regs, Shift_regs, Decr_P, busy, done, error}, ciclos);
        end
        @(negedge clk); rst = 1'b0;
        m = 8'($urandom); mc = 8'($urandom);
        run_op(m, mc, 1'b0);
        check_full_op("after_reset", m, mc);
    endtask

    task automatic test_start_held();
        logic [7:0] m, mc;
        bit found, stray;
        int cyc;
        m = 8'($urandom); mc = 8'($urandom);
        run_op(m, mc, 1'b1);
        check_full_op("held", m, mc);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL held_idle_gap: busy %b done %b expected 0/0", busy, done); end
        @(negedge clk);
        checks++;
        if (Load_regs !== 1'b1) begin errors++; $display("FAIL held_restart: Load_regs got %b expected 1", Load_regs); end
        start = 1'b0;
        found = 0; cyc = 0;
        for (int c = 1; c < 60; c++) begin
            @(negedge clk);
            if (done) begin found = 1; cyc = c; break; end
        end
        checks++;
        if (!found || cyc !== exp_cycles(m) || {dp_a, dp_q} !== 16'(m * mc)) begin
            errors++; $display("FAIL held_second_op: done %b at %0d product %h expected at %0d product %h",
                found, cyc, {dp_a, dp_q}, exp_cycles(m), 16'(m * mc));
        end
        // start held through the op but released during DONE: no second op
        run_op(m, mc, 1'b1);
        start = 1'b0;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy || done) stray = 1;
        end
        checks++;
        if (obs_done !== 1'b1 || stray !== 1'b0) begin
            errors++; $display("FAIL held_single_op: done %b stray %b expected 1/0", obs_done, stray);
        end
    endtask

    task automatic test_start_while_busy();
        logic [7:0] m, mc;
        bit found, stray;
        int cyc;
        m = 8'($urandom); mc = 8'($urandom);
        dp_mplier = m; dp_mcand = mc;
        found = 0; cyc = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c < 60; c++) begin
            @(negedge clk);
            start = (c == 6 || c == 15);
            if (done) begin found = 1; cyc = c; break; end
        end
        start = 1'b0;
        checks++;
        if (!found || cyc !== exp_cycles(m) || ciclos !== 8'(exp_cycles(m))) begin
            errors++; $display("FAIL busy_start_ignored: done %b at %0d ciclos %0d expected at %0d",
                found, cyc, ciclos, exp_cycles(m));
        end
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy || done) stray = 1;
        end
        checks++;
        if (stray !== 1'b0) begin errors++; $display("FAIL busy_start_queued: got 1 expected 0"); end
    endtask

    task automatic test_premature_zero();
        logic [7:0] m, mc;
        int exp_b;
        m = 8'($urandom); mc = 8'($urandom);
        exp_b = 1 + 9 + int'(m[0]) + int'(m[1]) + int'(m[2]);
        zero_mode = 1;
        run_op(m, mc, 1'b0);
        checks++;
        if (obs_err !== 1'b1 || obs_done !== 1'b0) begin
            errors++; $display("FAIL premature_zero: error %b done %b expected 1/0", obs_err, obs_done);
        end
        checks++;
        if (obs_busy !== exp_b || int'(obs_ciclos) !== exp_b) begin
            errors++; $display("FAIL premature_cycles: busy %0d ciclos %0d expected %0d", obs_busy, obs_ciclos, exp_b);
        end
        @(negedge clk); @(negedge clk);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || int'(ciclos) !== exp_b) begin
            errors++; $display("FAIL error_held: error %b busy %b done %b ciclos %0d expected 1/0/0/%0d",
                error, busy, done, ciclos, exp_b);
        end
        zero_mode = 0;
        m = 8'($urandom); mc = 8'($urandom);
        run_op(m, mc, 1'b0);
        checks++;
        if (obs_first_load !== 1'b1 || obs_first_err !== 1'b0) begin
            errors++; $display("FAIL error_restart: load %b error %b expected 1/0", obs_first_load, obs_first_err);
        end
        check_full_op("after_error", m, mc);
    endtask

    task automatic test_missing_zero();
        logic [7:0] m, mc;
        m = 8'($urandom); mc = 8'($urandom);
        zero_mode = 2;
        run_op(m, mc, 1'b0);
        checks++;
        if (obs_err !== 1'b1 || obs_done !== 1'b0 || obs_busy !== exp_cycles(m)) begin
            errors++; $display("FAIL missing_zero: error %b done %b busy %0d expected 1/0/%0d",
                obs_err, obs_done, obs_busy, exp_cycles(m));
        end
        zero_mode = 0;
        @(negedge clk); rst = 1'b1;
        #1;
        checks++;
        if (error !== 1'b0 || ciclos !== 8'd0) begin
            errors++; $display("FAIL reset_from_error: error %b ciclos %0d expected 0/0", error, ciclos);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_extremes();
        test_random();
        test_reset_mid();
        test_start_held();
        test_start_while_busy();
        test_premature_zero();
        test_missing_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
